// File: rtl/riscnet_pkg.sv
// ----------------------------------------------------------------------------
// riscnet_pkg
// Shared definitions for the 16-bit RISC pipeline issue logic:
//   - register index and opcode widths
//   - opcode constants OP_NOP..OP_MUL and ALU control constants ALU_*
//   - the issue FSM state type
//   - helpers that classify an opcode and map it to its ALU control
// ----------------------------------------------------------------------------
package riscnet_pkg;

    localparam int REG_W = 4;
    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADD = 6'h01;
    localparam logic [OPC_W-1:0] OP_SUB = 6'h02;
    localparam logic [OPC_W-1:0] OP_AND = 6'h03;
    localparam logic [OPC_W-1:0] OP_OR  = 6'h04;
    localparam logic [OPC_W-1:0] OP_XOR = 6'h05;
    localparam logic [OPC_W-1:0] OP_SHL = 6'h06;
    localparam logic [OPC_W-1:0] OP_SHR = 6'h07;
    localparam logic [OPC_W-1:0] OP_MUL = 6'h08;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    // Opcodes outside the table are illegal and get dropped at issue.
    function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
        return (opc <= OP_MUL);
    endfunction

    function automatic logic [3:0] alu_ctl_of(input logic [OPC_W-1:0] opc);
        logic [3:0] ctl;
        case (opc)
            OP_ADD:  ctl = ALU_ADD;
            OP_SUB:  ctl = ALU_SUB;
            OP_AND:  ctl = ALU_AND;
            OP_OR:   ctl = ALU_OR;
            OP_XOR:  ctl = ALU_XOR;
            OP_SHL:  ctl = ALU_SHL;
            OP_SHR:  ctl = ALU_SHR;
            OP_MUL:  ctl = ALU_MUL;
            default: ctl = ALU_NOP;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One pending-write bit per architectural register. R0 never becomes pending.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset (clears all)
//   i_set_en, i_set_reg      a new producer issued for i_set_reg
//   i_clr_en, i_clr_reg      writeback retiring i_clr_reg this cycle; also
//                            used as the same-cycle bypass for the read ports
//   i_kill_en, i_kill_reg    an in-flight producer was killed
//   i_rd_reg_a/b/c           registers to look up (src1, src2, dst)
//   o_hz_a/b/c               register still pending after the wb bypass
// ----------------------------------------------------------------------------
module reg_scoreboard
    import riscnet_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_reg,
    input  logic             i_clr_en,
    input  logic [REG_W-1:0] i_clr_reg,
    input  logic             i_kill_en,
    input  logic [REG_W-1:0] i_kill_reg,
    input  logic [REG_W-1:0] i_rd_reg_a,
    input  logic [REG_W-1:0] i_rd_reg_b,
    input  logic [REG_W-1:0] i_rd_reg_c,
    output logic             o_hz_a,
    output logic             o_hz_b,
    output logic             o_hz_c
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_next;

    // Clears are applied before the set so that a producer issuing in the
    // same cycle its predecessor retires keeps the register pending.
    always_comb begin
        w_pend_next = r_pend;
        if (i_clr_en) begin
            w_pend_next[i_clr_reg] = 1'b0;
        end
        if (i_kill_en) begin
            w_pend_next[i_kill_reg] = 1'b0;
        end
        if (i_set_en && (i_set_reg != '0)) begin
            w_pend_next[i_set_reg] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // A writeback landing this cycle satisfies the reader immediately.
    assign o_hz_a = r_pend[i_rd_reg_a] & ~(i_clr_en & (i_clr_reg == i_rd_reg_a));
    assign o_hz_b = r_pend[i_rd_reg_b] & ~(i_clr_en & (i_clr_reg == i_rd_reg_b));
    assign o_hz_c = r_pend[i_rd_reg_c] & ~(i_clr_en & (i_clr_reg == i_rd_reg_c));

endmodule

// File: rtl/execute_issue_controller.sv
// ----------------------------------------------------------------------------
// execute_issue_controller
// Decides each cycle whether the decoded instruction issues to EX or holds
// decode, tracks pending register writes, translates opcodes to ALU control
// and sequences the multi-cycle MUL.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid, id_opcode         decoded instruction valid / opcode
//   id_src1, id_src2, id_dst    source and destination registers
//   id_writes                   instruction writes id_dst
//   wb_valid, wb_reg            writeback retiring wb_reg this cycle
//   flush                       kill decode instruction and in-flight MUL
//   id_stall                    combinational hold for decode/fetch
//   ex_valid, ex_alu_ctl,
//   ex_wb_reg, ex_writes        registered EX-stage instruction
//   illegal_op                  registered pulse: illegal opcode dropped
//   busy                        registered: a MUL occupies EX
// ----------------------------------------------------------------------------
module execute_issue_controller
    import riscnet_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int MUL_LAT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_writes,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [3:0]       ex_alu_ctl,
    output logic [REG_W-1:0] ex_wb_reg,
    output logic             ex_writes,
    output logic             illegal_op,
    output logic             busy
);

    localparam int CNT_W = $clog2(MUL_LAT);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_ex_valid;
    logic [3:0]       r_ex_alu_ctl;
    logic [REG_W-1:0] r_ex_wb_reg;
    logic             r_ex_writes;
    logic             r_illegal_op;
    logic             r_busy;

    logic             w_ex_valid_next;
    logic [3:0]       w_ex_alu_ctl_next;
    logic [REG_W-1:0] w_ex_wb_reg_next;
    logic             w_ex_writes_next;
    logic             w_illegal_next;
    logic             w_busy_next;

    logic             w_hz_src1;
    logic             w_hz_src2;
    logic             w_hz_dst;
    logic             w_raw_hz;
    logic             w_waw_hz;
    logic             w_stall;
    logic             w_legal;
    logic             w_is_mul;
    logic             w_can_go;
    logic             w_issue;
    logic             w_kill;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_issue & id_writes),
        .i_set_reg  (id_dst),
        .i_clr_en   (wb_valid),
        .i_clr_reg  (wb_reg),
        .i_kill_en  (w_kill),
        .i_kill_reg (r_ex_wb_reg),
        .i_rd_reg_a (id_src1),
        .i_rd_reg_b (id_src2),
        .i_rd_reg_c (id_dst),
        .o_hz_a     (w_hz_src1),
        .o_hz_b     (w_hz_src2),
        .o_hz_c     (w_hz_dst)
    );

    assign w_legal  = opcode_legal(id_opcode);
    assign w_is_mul = (id_opcode == OP_MUL);
    assign w_raw_hz = id_valid & (w_hz_src1 | w_hz_src2);
    assign w_waw_hz = id_valid & id_writes & w_hz_dst;

    // The cycle a MUL issues from RUN is not a stall; only the following
    // MULTI cycles hold decode.
    assign w_stall  = w_raw_hz | w_waw_hz | (r_state == MULTI);
    assign w_can_go = id_valid & ~w_stall & ~flush;
    assign w_issue  = w_can_go & w_legal;

    // Killing the MUL in flight releases its destination in the scoreboard.
    assign w_kill   = (r_state == MULTI) & flush & r_ex_writes;

    assign id_stall = w_stall;

    // Next-state and next-EX logic. EX fields default to an empty slot.
    // busy tracks EX occupancy by the MUL, so it stays high through the last
    // MULTI cycle's successor, when the MUL is still in EX.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_ex_valid_next   = 1'b0;
        w_ex_alu_ctl_next = ALU_NOP;
        w_ex_wb_reg_next  = '0;
        w_ex_writes_next  = 1'b0;
        w_busy_next       = 1'b0;
        w_illegal_next    = w_can_go & ~w_legal;

        case (r_state)
            RUN: begin
                if (w_issue) begin
                    w_ex_valid_next   = 1'b1;
                    w_ex_alu_ctl_next = alu_ctl_of(id_opcode);
                    w_ex_wb_reg_next  = id_dst;
                    w_ex_writes_next  = id_writes;
                    if (w_is_mul) begin
                        w_state_next = MULTI;
                        w_cnt_next   = CNT_W'(MUL_LAT - 1);
                        w_busy_next  = 1'b1;
                    end
                end
            end
            MULTI: begin
                if (flush) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_ex_valid_next   = r_ex_valid;
                    w_ex_alu_ctl_next = r_ex_alu_ctl;
                    w_ex_wb_reg_next  = r_ex_wb_reg;
                    w_ex_writes_next  = r_ex_writes;
                    w_busy_next       = 1'b1;
                    w_cnt_next        = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = RUN;
                    end
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_alu_ctl <= ALU_NOP;
            r_ex_wb_reg  <= '0;
            r_ex_writes  <= 1'b0;
            r_illegal_op <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_ex_valid   <= w_ex_valid_next;
            r_ex_alu_ctl <= w_ex_alu_ctl_next;
            r_ex_wb_reg  <= w_ex_wb_reg_next;
            r_ex_writes  <= w_ex_writes_next;
            r_illegal_op <= w_illegal_next;
            r_busy       <= w_busy_next;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_alu_ctl = r_ex_alu_ctl;
    assign ex_wb_reg  = r_ex_wb_reg;
    assign ex_writes  = r_ex_writes;
    assign illegal_op = r_illegal_op;
    assign busy       = r_busy;

endmodule
